fpu_arbiter: RTL and testbench

- Shares one multi-cycle FPU adder (32-bit format: 1 sign, 6-bit exponent with bias 31, 25-bit mantissa) between N_REQ requesters.
- Accepts operand pairs over valid/ready, arbitrates round-robin, and restarts the FPU with a glitch-free registered reset pulse.
- Waits a fixed FPU_LATENCY cycles, captures data_out/status_out, and returns them to the granted requester over a valid/ready response channel.
- Sits between the requester clients and the FPU instance; the FPU has no start/done signals, so this block is its sole sequencer.

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/fpu_arbiter.sv | 154 +++++++++++++++
 tb/tb_fpu_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared constants and types for the FPU arbiter slice: number format,
// status bit positions and the sequencer state encoding.
package fpu_pkg;

    localparam int unsigned FP_W     = 32;
    localparam int unsigned EXP_W    = 6;
    localparam int unsigned MANT_W   = 25;
    localparam int unsigned EXP_BIAS = 31;
    localparam int unsigned STATUS_W = 4;

    localparam int unsigned ST_ZERO     = 0;
    localparam int unsigned ST_SIGN     = 1;
    localparam int unsigned ST_OVERFLOW = 2;
    localparam int unsigned ST_INVALID  = 3;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_word_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first active request
// found after last_grant_i, wrapping around.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [$clog2(N_REQ)-1:0] last_grant_i,
    input  logic [N_REQ-1:0]         req_i,
    output logic [N_REQ-1:0]         grant_o
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((32'(last_grant_i) + k) % N_REQ);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Sequences one shared multi-cycle FPU adder between N_REQ requesters:
// round-robin accept, FPU reset pulse, fixed-latency wait, held response.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned FPU_LATENCY = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*FP_W-1:0] req_op_a,
    input  logic [N_REQ*FP_W-1:0] req_op_b,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [FP_W-1:0]       rsp_data,
    output logic [STATUS_W-1:0]   rsp_status,
    output logic                  busy,
    output logic                  fpu_reset_n,
    output logic [FP_W-1:0]       fpu_op_a,
    output logic [FP_W-1:0]       fpu_op_b,
    input  logic [FP_W-1:0]       fpu_data_in,
    input  logic [STATUS_W-1:0]   fpu_status_in
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fpu_rst_n_q, fpu_rst_n_d;
    logic [FP_W-1:0]    op_a_q, op_a_d;
    logic [FP_W-1:0]    op_b_q, op_b_d;
    logic [FP_W-1:0]    data_q, data_d;
    logic [STATUS_W-1:0] status_q, status_d;

    logic [N_REQ-1:0]   rr_grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [FP_W-1:0]    sel_a, sel_b;
    logic               handshake;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .last_grant_i (last_grant_q),
        .req_i        (req_valid),
        .grant_o      (rr_grant)
    );

    always_comb begin
        grant_idx = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rr_grant[i]) begin
                grant_idx = IDX_W'(i);
                sel_a     = req_op_a[i*FP_W +: FP_W];
                sel_b     = req_op_b[i*FP_W +: FP_W];
            end
        end
    end

    // fpu_rst_n_q is low for the first cycle after reset release, which also
    // keeps req_ready quiet until the FPU reset pin has been driven high.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && fpu_rst_n_q) begin
            req_ready = rr_grant;
        end
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[grant_q] = 1'b1;
        end
        busy      = (state_q != IDLE);
        handshake = |(req_valid & req_ready);
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        data_d       = data_q;
        status_d     = status_q;
        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    op_a_d  = sel_a;
                    op_b_d  = sel_b;
                    grant_d = grant_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = CNT_W'(FPU_LATENCY - 1);
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q == '0) begin
                    data_d   = fpu_data_in;
                    status_d = fpu_status_in;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Derived from the next state so the FPU reset pin comes straight off a flop.
        fpu_rst_n_d = (state_d != LOAD);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(N_REQ - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
            fpu_rst_n_q  <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            data_q       <= '0;
            status_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            fpu_rst_n_q  <= fpu_rst_n_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            data_q       <= data_d;
            status_q     <= status_d;
        end
    end

    assign fpu_reset_n = fpu_rst_n_q;
    assign fpu_op_a    = op_a_q;
    assign fpu_op_b    = op_b_q;
    assign rsp_data    = data_q;
    assign rsp_status  = status_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter: behavioural FPU stand-in, transaction
// level reference model, directed scenarios plus randomized traffic.
module tb_fpu_arbiter;
    import fpu_pkg::*;

    localparam int unsigned N   = 2;
    localparam int unsigned LAT = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- number helpers (exact for the small operand pool) ----------------
    function automatic real fp_to_real(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        e = int'(x[30:25]) - 31;
        m = 1.0 + real'(x[24:0]) / 33554432.0;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] real_to_fp(input real v);
        real         r;
        int          e;
        logic        s;
        logic [31:0] mi;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        r = s ? -v : v;
        e = 31;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0)  begin r = r * 2.0; e--; end
        mi = 32'($rtoi((r - 1.0) * 33554432.0));
        return {s, 6'(e), mi[24:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return real_to_fp(fp_to_real(a) + fp_to_real(b));
    endfunction

    function automatic logic [3:0] fp_stat(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [3:0]  s;
        r = fp_add(a, b);
        s = '0;
        s[ST_ZERO]     = (r == 32'h0);
        s[ST_SIGN]     = r[31];
        s[ST_OVERFLOW] = 1'b0;
        s[ST_INVALID]  = a[31] ^ b[31];
        return s;
    endfunction

    real pool [12] = '{0.0, 0.5, -0.5, 1.0, -1.0, 1.5, -1.5, 2.0, -2.0, 3.0, 0.25, -0.25};

    // ---------------- main DUT ----------------
    logic [N-1:0]      pend;
    logic [31:0]       opa [N];
    logic [31:0]       opb [N];
    logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*32-1:0]   req_op_a, req_op_b;
    logic [31:0]       rsp_data, fpu_op_a, fpu_op_b, fpu_data_in;
    logic [3:0]        rsp_status, fpu_status_in;
    logic              busy, fpu_reset_n;
    int unsigned       fcnt = 0;

    assign req_valid = pend;
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_op_a[i*32 +: 32] = opa[i];
            req_op_b[i*32 +: 32] = opb[i];
        end
    end

    fpu_arbiter #(.N_REQ(N), .FPU_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_status(rsp_status),
        .busy(busy), .fpu_reset_n(fpu_reset_n),
        .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
        .fpu_data_in(fpu_data_in), .fpu_status_in(fpu_status_in)
    );

    // FPU stand-in: result valid only once LAT edges have passed since reset release.
    always @(posedge clock) begin
        if (!fpu_reset_n) fcnt <= 0;
        else if (fcnt < 1000) fcnt <= fcnt + 1;
    end
    always_comb begin
        if (fpu_reset_n && fcnt >= LAT - 1) begin
            fpu_data_in   = fp_add(fpu_op_a, fpu_op_b);
            fpu_status_in = fp_stat(fpu_op_a, fpu_op_b);
        end else begin
            fpu_data_in   = 32'hDEADBEEF;
            fpu_status_in = 4'hA;
        end
    end

    // ---------------- FPU_LATENCY=1 DUT ----------------
    logic [N-1:0]    p_valid, p_ready, p_rv, p_rr;
    logic [N*32-1:0] p_opa, p_opb;
    logic [31:0]     p_data, p_fa, p_fb, p_fdi;
    logic [3:0]      p_stat, p_fsi;
    logic            p_busy, p_frn;
    int unsigned     fcnt1 = 0;

    fpu_arbiter #(.N_REQ(N), .FPU_LATENCY(1)) dut_l1 (
        .clock(clock), .reset(reset),
        .req_valid(p_valid), .req_ready(p_ready),
        .req_op_a(p_opa), .req_op_b(p_opb),
        .rsp_valid(p_rv), .rsp_ready(p_rr),
        .rsp_data(p_data), .rsp_status(p_stat),
        .busy(p_busy), .fpu_reset_n(p_frn),
        .fpu_op_a(p_fa), .fpu_op_b(p_fb),
        .fpu_data_in(p_fdi), .fpu_status_in(p_fsi)
    );

    always @(posedge clock) begin
        if (!p_frn) fcnt1 <= 0;
        else if (fcnt1 < 1000) fcnt1 <= fcnt1 + 1;
    end
    always_comb begin
        if (p_frn) begin
            p_fdi = fp_add(p_fa, p_fb);
            p_fsi = fp_stat(p_fa, p_fb);
        end else begin
            p_fdi = 32'hDEADBEEF;
            p_fsi = 4'hA;
        end
    end

    // ---------------- transaction-level reference model ----------------
    bit          m_busy = 0, m_fresh = 1;
    int unsigned m_last = N - 1, m_g = 0, m_t = 0;
    logic [31:0] m_a = '0, m_b = '0;

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int unsigned last);
        logic [N-1:0] r;
        int unsigned  j;
        r = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            j = (last + k) % N;
            if (r == '0 && ((v >> j) & N'(1)) != '0) r = N'(1) << j;
        end
        return r;
    endfunction

    task automatic model_step();
        logic [N-1:0] er;
        if (!reset) begin
            check_eq("rst_req_ready", req_ready, 0);
            check_eq("rst_rsp_valid", rsp_valid, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_fpu_reset_n", fpu_reset_n, 0);
            check_eq("rst_fpu_op_a", fpu_op_a, 0);
            check_eq("rst_fpu_op_b", fpu_op_b, 0);
            check_eq("rst_rsp_data", rsp_data, 0);
            check_eq("rst_rsp_status", rsp_status, 0);
            m_busy = 0; m_last = N - 1; m_a = '0; m_b = '0; m_fresh = 1;
        end else if (m_fresh) begin
            check_eq("post_rst_req_ready", req_ready, 0);
            check_eq("post_rst_busy", busy, 0);
            check_eq("post_rst_rsp_valid", rsp_valid, 0);
            m_fresh = 0;
        end else if (!m_busy) begin
            er = rr_pick(req_valid, m_last);
            check_eq("idle_req_ready", req_ready, er);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_rsp_valid", rsp_valid, 0);
            check_eq("idle_fpu_reset_n", fpu_reset_n, 1);
            check_eq("idle_fpu_op_a", fpu_op_a, m_a);
            check_eq("idle_fpu_op_b", fpu_op_b, m_b);
            if (er != '0) begin
                for (int unsigned j = 0; j < N; j++)
                    if (((er >> j) & N'(1)) != '0) m_g = j;
                m_a = opa[m_g]; m_b = opb[m_g];
                m_busy = 1; m_t = 1;
            end
        end else begin
            check_eq("busy_busy", busy, 1);
            check_eq("busy_req_ready", req_ready, 0);
            check_eq("busy_fpu_reset_n", fpu_reset_n, (m_t != 1));
            check_eq("busy_fpu_op_a", fpu_op_a, m_a);
            check_eq("busy_fpu_op_b", fpu_op_b, m_b);
            if (m_t >= LAT + 2) begin
                check_eq("resp_rsp_valid", rsp_valid, N'(1) << m_g);
                check_eq("resp_rsp_data", rsp_data, fp_add(m_a, m_b));
                check_eq("resp_rsp_status", rsp_status, fp_stat(m_a, m_b));
                if (((rsp_ready >> m_g) & N'(1)) != '0) begin
                    m_busy = 0; m_last = m_g;
                end
            end else begin
                check_eq("wait_rsp_valid", rsp_valid, 0);
                m_t++;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            #1;
            model_step();
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] hs;

    task automatic tick();
        #2;
        hs = req_valid & req_ready;
        @(negedge clock);
        pend = pend & ~hs;
    endtask

    task automatic wait_quiet(input int unsigned limit);
        int unsigned c = 0;
        while ((pend != '0 || busy) && c < limit) begin
            tick();
            c++;
        end
        check_eq("quiet_timeout", c < limit, 1);
    endtask

    task automatic wait_rsp(output int unsigned cyc);
        cyc = 0;
        while (rsp_valid == '0 && cyc < 40) begin
            tick();
            cyc++;
        end
        check_eq("rsp_timeout", cyc < 40, 1);
    endtask

    task automatic wait_hs(output logic [N-1:0] got);
        int unsigned c = 0;
        got = '0;
        while (got == '0 && c < 40) begin
            tick();
            got = hs;
            c++;
        end
    endtask

    int unsigned cyc;
    logic [N-1:0] g;

    initial begin
        pend = '0; rsp_ready = '1;
        for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
        p_valid = '0; p_rr = '1; p_opa = '0; p_opb = '0;

        // contention held from reset
        opa[0] = 32'h3F000000; opb[0] = 32'h3C000000;
        opa[1] = 32'h3E000000; opb[1] = 32'h00000000;
        pend = 2'b11;
        repeat (3) tick();
        reset = 1'b1;
        wait_hs(g);
        check_eq("contend_first_grant", g, 2'b01);
        wait_rsp(cyc);
        check_eq("contend_first_data", rsp_data, 32'h40000000);
        wait_hs(g);
        check_eq("contend_second_grant", g, 2'b10);
        wait_rsp(cyc);
        check_eq("contend_second_data", rsp_data, 32'h3E000000);
        pend = 2'b11;
        wait_hs(g);
        check_eq("contend_third_grant", g, 2'b01);
        wait_quiet(100);

        // single request, latency and reset pulse
        opa[0] = 32'h3E000000; opb[0] = 32'h3E000000; pend = 2'b01;
        tick();
        check_eq("pulse_low_cycle1", fpu_reset_n, 0);
        tick();
        check_eq("pulse_high_cycle2", fpu_reset_n, 1);
        wait_rsp(cyc);
        check_eq("single_latency", 2 + cyc, LAT + 2);
        check_eq("single_valid", rsp_valid, 2'b01);
        check_eq("single_data", rsp_data, 32'h40000000);
        check_eq("single_status", rsp_status, fp_stat(32'h3E000000, 32'h3E000000));
        wait_quiet(20);

        // cancelling operands on requester 1
        opa[1] = 32'h3E000000; opb[1] = 32'hBE000000; pend = 2'b10;
        wait_rsp(cyc);
        check_eq("cancel_valid", rsp_valid, 2'b10);
        check_eq("cancel_data", rsp_data, 32'h00000000);
        wait_quiet(20);

        // response backpressure; requester 1 ready is ignored, its request waits
        rsp_ready = 2'b10;
        opa[0] = real_to_fp(2.0); opb[0] = real_to_fp(1.0); pend = 2'b01;
        wait_rsp(cyc);
        opa[1] = real_to_fp(0.5); opb[1] = real_to_fp(0.5); pend[1] = 1'b1;
        repeat (5) begin
            tick();
            check_eq("bp_valid", rsp_valid, 2'b01);
            check_eq("bp_data", rsp_data, real_to_fp(3.0));
            check_eq("bp_req_ready", req_ready, 0);
            check_eq("bp_busy", busy, 1);
        end
        rsp_ready = 2'b01;
        tick();
        check_eq("bp_release_idle", busy, 0);
        check_eq("bp_release_ready", req_ready, 2'b10);
        rsp_ready = '1;
        wait_quiet(40);

        // reset during RUN
        opa[0] = real_to_fp(0.5); opb[0] = real_to_fp(0.25); pend = 2'b01;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check_eq("midrun_busy", busy, 0);
        check_eq("midrun_fpu_reset_n", fpu_reset_n, 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (20) begin
            tick();
            check_eq("midrun_no_rsp", rsp_valid, 0);
        end
        opa[1] = real_to_fp(1.5); opb[1] = real_to_fp(1.5); pend = 2'b10;
        wait_rsp(cyc);
        check_eq("after_rst_data", rsp_data, real_to_fp(3.0));
        wait_quiet(20);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(3) == 0) begin
                    opa[i] = real_to_fp(pool[$urandom_range(11)]);
                    opb[i] = real_to_fp(pool[$urandom_range(11)]);
                    pend[i] = 1'b1;
                end else if (pend[i] && busy && $urandom_range(15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            rsp_ready = N'($urandom_range((1 << N) - 1));
            tick();
        end
        rsp_ready = '1;
        wait_quiet(100);

        // FPU_LATENCY=1 instance
        p_opa[63:32] = 32'h3C000000; p_opb[63:32] = 32'h3C000000;
        p_valid = 2'b10;
        #1;
        check_eq("l1_ready", p_ready, 2'b10);
        tick();
        p_valid = '0;
        #1;
        check_eq("l1_pulse_low", p_frn, 0);
        tick();
        #1;
        check_eq("l1_no_valid_c2", p_rv, 0);
        check_eq("l1_busy_c2", p_busy, 1);
        tick();
        #1;
        check_eq("l1_valid_c3", p_rv, 2'b10);
        check_eq("l1_data", p_data, 32'h3E000000);
        tick();
        #1;
        check_eq("l1_idle_c4", p_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
